qsfp_reset_sequencer: RTL and testbench
=======================================

QSFP_RESET_SEQUENCER -- requirements
Module: qsfp_reset_sequencer

Interface
REQ-001 Parameter CH_CNT, default 8: number of PHY channels monitored for block lock.
REQ-002 Parameter REFCLK_RST_CYCLES, default 1024: cycles spent in REFCLK_RST.
REQ-003 Parameter SETTLE_CYCLES, default 1024: cycles spent in SETTLE.
REQ-004 Parameter TIMEOUT_CYCLES, default 65536: maximum cycles spent in MMCM_WAIT, GT_WAIT or LINK_WAIT.
REQ-005 Parameter MAX_RETRY, default 3, range 0-15: retries allowed before FAULT.
REQ-006 Clock and reset ports SHALL be as follows:
- clk, input, 1: sole clock, free-running config clock.
- rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Other ports SHALL be as follows:
- mmcm_locked, input, 1: MMCM lock, asynchronous to clk.
- gtpowergood, input, 1: transceiver power good, asynchronous.
- rx_block_lock, input, CH_CNT: per-channel PCS block lock, asynchronous.
- restart, input, 1: single-cycle restart request.
- qsfp_refclk_reset, output, 1: clock generator reset, high = reset.
- mmcm_rst, output, 1: MMCM reset, high = reset.
- xcvr_rst, output, 1: transceiver/PHY reset, high = reset.
- qsfp_resetl, output, 1: module reset, low = reset.
- ready, output, 1: sequence complete.
- link_ok, output, 1: all channels locked.
- fault, output, 1: retries exhausted.
- state, output, 3: current state encoding.
- retry_cnt, output, 4: retries consumed.

Function
REQ-008 mmcm_locked, gtpowergood and each rx_block_lock bit SHALL pass through 2-flop synchronizers; all decisions use the synchronized (_s) values.
REQ-009 State encoding SHALL be: REFCLK_RST=0, SETTLE=1, MMCM_WAIT=2, GT_WAIT=3, LINK_WAIT=4, RUN=5, FAULT=6.
REQ-010 A single timer SHALL clear on every state change and increment otherwise, saturating at TIMEOUT_CYCLES-1.
REQ-011 REFCLK_RST SHALL assert all four resets (qsfp_resetl=0) and SHALL go to SETTLE when timer==REFCLK_RST_CYCLES-1.
REQ-012 SETTLE SHALL deassert qsfp_refclk_reset, hold the other resets, and SHALL go to MMCM_WAIT when timer==SETTLE_CYCLES-1.
REQ-013 MMCM_WAIT SHALL deassert mmcm_rst, SHALL go to GT_WAIT when mmcm_locked_s=1, and SHALL otherwise take the retry path when timer==TIMEOUT_CYCLES-1.
REQ-014 GT_WAIT SHALL go to LINK_WAIT when gtpowergood_s=1; if mmcm_locked_s drops or the timeout expires, it SHALL take the retry path.
REQ-015 LINK_WAIT SHALL deassert xcvr_rst and set qsfp_resetl=1.
- It SHALL go to RUN when &rx_block_lock_s=1 or on timeout; no retry, since unplugged ports are legal.
REQ-016 RUN SHALL set ready=1.
- If mmcm_locked_s=0 or gtpowergood_s=0, it SHALL take the retry path.
- Block-lock loss SHALL only clear link_ok.
REQ-017 Retry path: if retry_cnt<MAX_RETRY, retry_cnt increments and the next state is REFCLK_RST; otherwise the next state is FAULT.
REQ-018 FAULT SHALL assert all resets, set fault=1 and ready=0, and be left only via restart or rst_n.
REQ-019 restart=1 in any state SHALL force REFCLK_RST and retry_cnt=0 on the next edge.
- This SHALL take priority over a timeout or any other transition in the same cycle.
REQ-020 retry_cnt SHALL be cleared only by restart or rst_n, never by reaching RUN.
REQ-021 All outputs SHALL be registered and SHALL change on the same edge as the state register; they SHALL never be decoded combinationally.
REQ-022 link_ok SHALL be a register equal to &rx_block_lock_s in LINK_WAIT and RUN, and 0 elsewhere.
REQ-023 ready SHALL be 1 only in RUN.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock edge, force the following values:
- state=REFCLK_RST, timer=0, retry_cnt=0.
- qsfp_refclk_reset=1, mmcm_rst=1, xcvr_rst=1, qsfp_resetl=0.
- ready=0, link_ok=0, fault=0, all synchronizer flops=0.
REQ-025 Release of rst_n SHALL restart the REFCLK_RST count from timer=0.

Verification
Bench parameters: CH_CNT=4, REFCLK_RST_CYCLES=8, SETTLE_CYCLES=4, TIMEOUT_CYCLES=32, MAX_RETRY=2.
REQ-026 Nominal: release rst_n with mmcm_locked=1, gtpowergood=1, rx_block_lock=4'hF.
- Required: qsfp_refclk_reset falls 8 cycles after release and mmcm_rst falls 4 cycles later.
- Required: state sequence 0,1,2,3,4,5, ending with ready=1, link_ok=1, fault=0.
REQ-027 MMCM never locks:
- Required: three MMCM_WAIT timeouts of 32 cycles each.
- Required: retry_cnt steps 1 then 2, then state=6, fault=1, all resets asserted.
REQ-028 In RUN, drop mmcm_locked:
- Required: within 3 cycles state=0, ready=0, retry_cnt=1.
- Required: after re-lock, RUN is reached again.
REQ-029 rx_block_lock=4'b0111:
- Required: RUN after 32 cycles in LINK_WAIT, with ready=1 and link_ok=0.
- Then set 4'hF; required: link_ok=1 within 3 cycles.
REQ-030 restart on the same cycle as an MMCM_WAIT timeout:
- Required: next state=0, retry_cnt=0.
- restart while in FAULT; required: fault=0 and state=0 on the next edge.
REQ-031 rst_n asserted mid-LINK_WAIT between clock edges:
- Required: all outputs take their REQ-024 values before the next edge.

Source files
------------

// File: rtl/qsfp_reset_sequencer.sv
// QSFP bring-up sequencer: steps the reference clock generator, MMCM,
// transceiver and module resets in order, waits for each stage to come up,
// retries a bounded number of times and parks in FAULT when retries run out.
module qsfp_reset_sequencer #(
   parameter int CH_CNT            = 8,
   parameter int REFCLK_RST_CYCLES = 1024,
   parameter int SETTLE_CYCLES     = 1024,
   parameter int TIMEOUT_CYCLES    = 65536,
   parameter int MAX_RETRY         = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mmcm_locked,
   input  logic              gtpowergood,
   input  logic [CH_CNT-1:0] rx_block_lock,
   input  logic              restart,
   output logic              qsfp_refclk_reset,
   output logic              mmcm_rst,
   output logic              xcvr_rst,
   output logic              qsfp_resetl,
   output logic              ready,
   output logic              link_ok,
   output logic              fault,
   output logic [2:0]        state,
   output logic [3:0]        retry_cnt
);

   typedef enum logic [2:0] {
      REFCLK_RST = 3'd0,
      SETTLE     = 3'd1,
      MMCM_WAIT  = 3'd2,
      GT_WAIT    = 3'd3,
      LINK_WAIT  = 3'd4,
      RUN        = 3'd5,
      FAULT      = 3'd6
   } state_t;

   // The timer saturates at the timeout value, so the fixed dwell counts
   // must not exceed TIMEOUT_CYCLES or their terminal count is never seen.
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] REFCLK_LAST = TW'(REFCLK_RST_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

   logic              mmcm_locked_m, mmcm_locked_s;
   logic              gtpowergood_m, gtpowergood_s;
   logic [CH_CNT-1:0] rx_block_lock_m, rx_block_lock_s;
   logic              all_locked;

   state_t            state_reg, state_next;
   logic [TW-1:0]     timer_reg, timer_next;
   logic [3:0]        retry_next;
   logic              take_retry;
   logic              timed_out;

   // Two-flop synchronizers for the single-bit status inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mmcm_locked_m <= 1'b0;
         mmcm_locked_s <= 1'b0;
         gtpowergood_m <= 1'b0;
         gtpowergood_s <= 1'b0;
      end else begin
         mmcm_locked_m <= mmcm_locked;
         mmcm_locked_s <= mmcm_locked_m;
         gtpowergood_m <= gtpowergood;
         gtpowergood_s <= gtpowergood_m;
      end
   end

   // One independent two-flop synchronizer per channel block-lock bit
   for (genvar gi = 0; gi < CH_CNT; gi++) begin : g_lock_sync
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rx_block_lock_m[gi] <= 1'b0;
            rx_block_lock_s[gi] <= 1'b0;
         end else begin
            rx_block_lock_m[gi] <= rx_block_lock[gi];
            rx_block_lock_s[gi] <= rx_block_lock_m[gi];
         end
      end
   end

   assign all_locked = &rx_block_lock_s;
   assign timed_out  = (timer_reg == TMO_LAST);
   assign state      = state_reg;

   // Next-state, retry and timer decisions; restart overrides everything
   always_comb begin
      state_next = state_reg;
      retry_next = retry_cnt;
      take_retry = 1'b0;
      case (state_reg)
         REFCLK_RST: if (timer_reg == REFCLK_LAST) state_next = SETTLE;
         SETTLE:     if (timer_reg == SETTLE_LAST) state_next = MMCM_WAIT;
         MMCM_WAIT: begin
            if (mmcm_locked_s)  state_next = GT_WAIT;
            else if (timed_out) take_retry = 1'b1;
         end
         GT_WAIT: begin
            if (gtpowergood_s)                      state_next = LINK_WAIT;
            else if (!mmcm_locked_s || timed_out)   take_retry = 1'b1;
         end
         // Missing lanes are legal (unplugged ports), so a timeout still runs
         LINK_WAIT:  if (all_locked || timed_out) state_next = RUN;
         RUN:        if (!mmcm_locked_s || !gtpowergood_s) take_retry = 1'b1;
         FAULT:      state_next = FAULT;
         default:    state_next = REFCLK_RST;
      endcase
      if (take_retry) begin
         if (retry_cnt < RETRY_MAX) begin
            retry_next = retry_cnt + 4'd1;
            state_next = REFCLK_RST;
         end else begin
            state_next = FAULT;
         end
      end
      if (restart) begin
         state_next = REFCLK_RST;
         retry_next = 4'd0;
      end
      if (restart || (state_next != state_reg)) timer_next = '0;
      else if (!timed_out)                      timer_next = timer_reg + TW'(1);
      else                                      timer_next = timer_reg;
   end

   // State register with outputs decoded from the next state so that they
   // all switch on the same edge as the state itself
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= REFCLK_RST;
         timer_reg         <= '0;
         retry_cnt         <= 4'd0;
         qsfp_refclk_reset <= 1'b1;
         mmcm_rst          <= 1'b1;
         xcvr_rst          <= 1'b1;
         qsfp_resetl       <= 1'b0;
         ready             <= 1'b0;
         link_ok           <= 1'b0;
         fault             <= 1'b0;
      end else begin
         state_reg         <= state_next;
         timer_reg         <= timer_next;
         retry_cnt         <= retry_next;
         qsfp_refclk_reset <= (state_next == REFCLK_RST) || (state_next == FAULT);
         mmcm_rst          <= (state_next == REFCLK_RST) || (state_next == SETTLE) ||
                              (state_next == FAULT);
         xcvr_rst          <= !((state_next == LINK_WAIT) || (state_next == RUN));
         qsfp_resetl       <= (state_next == LINK_WAIT) || (state_next == RUN);
         ready             <= (state_next == RUN);
         fault             <= (state_next == FAULT);
         link_ok           <= ((state_next == LINK_WAIT) || (state_next == RUN)) && all_locked;
      end
   end

endmodule

// File: tb/tb_qsfp_reset_sequencer.sv
// Bench for qsfp_reset_sequencer: directed vector table, hand-written
// corner sequences, then randomized inputs against a behavioural model.
module tb_qsfp_reset_sequencer;

   localparam int CH    = 4;
   localparam int T_REF = 8;
   localparam int T_SET = 4;
   localparam int T_TMO = 32;
   localparam int M_RTY = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       mmcm_locked = 1'b0;
   logic       gtpowergood = 1'b0;
   logic [3:0] rx_block_lock = 4'h0;
   logic       restart = 1'b0;
   logic       qsfp_refclk_reset, mmcm_rst, xcvr_rst, qsfp_resetl;
   logic       ready, link_ok, fault;
   logic [2:0] state;
   logic [3:0] retry_cnt;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   qsfp_reset_sequencer #(
      .CH_CNT(CH), .REFCLK_RST_CYCLES(T_REF), .SETTLE_CYCLES(T_SET),
      .TIMEOUT_CYCLES(T_TMO), .MAX_RETRY(M_RTY)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mmcm_locked(mmcm_locked), .gtpowergood(gtpowergood),
      .rx_block_lock(rx_block_lock), .restart(restart),
      .qsfp_refclk_reset(qsfp_refclk_reset), .mmcm_rst(mmcm_rst), .xcvr_rst(xcvr_rst),
      .qsfp_resetl(qsfp_resetl), .ready(ready), .link_ok(link_ok), .fault(fault),
      .state(state), .retry_cnt(retry_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // ---------------- behavioural reference model ----------------
   typedef struct {
      int         st;
      int         timer;
      int         retry;
      logic       link;
      logic       mm_m, mm_s, gt_m, gt_s;
      logic [3:0] lk_m, lk_s;
   } model_t;

   model_t m;

   function automatic model_t model_reset();
      model_t r;
      r.st = 0; r.timer = 0; r.retry = 0; r.link = 1'b0;
      r.mm_m = 1'b0; r.mm_s = 1'b0; r.gt_m = 1'b0; r.gt_s = 1'b0;
      r.lk_m = 4'h0; r.lk_s = 4'h0;
      return r;
   endfunction

   // How long each timed phase may last before its deadline
   function automatic int dwell(input int st);
      if (st == 0) return T_REF;
      if (st == 1) return T_SET;
      return T_TMO;
   endfunction

   function automatic model_t model_step(input model_t c, input logic mm, input logic gt,
                                         input logic [3:0] lk, input logic rs);
      model_t n = c;
      int     nxt = c.st;
      bit     want_retry = 1'b0;
      bit     expired = (c.timer == dwell(c.st) - 1);
      case (c.st)
         0, 1: if (expired) nxt = c.st + 1;
         2: if (c.mm_s) nxt = 3; else if (expired) want_retry = 1'b1;
         3: if (c.gt_s) nxt = 4; else if (!c.mm_s || expired) want_retry = 1'b1;
         4: if ((c.lk_s == 4'hF) || expired) nxt = 5;
         5: if (!c.mm_s || !c.gt_s) want_retry = 1'b1;
         default: ;
      endcase
      if (want_retry) begin
         if (c.retry < M_RTY) begin n.retry = c.retry + 1; nxt = 0; end
         else nxt = 6;
      end
      if (rs) begin nxt = 0; n.retry = 0; end
      if (rs || nxt != c.st) n.timer = 0;
      else n.timer = (c.timer + 1 > T_TMO - 1) ? T_TMO - 1 : c.timer + 1;
      n.link = ((nxt == 4) || (nxt == 5)) && (c.lk_s == 4'hF);
      n.st = nxt;
      n.mm_m = mm; n.mm_s = c.mm_m;
      n.gt_m = gt; n.gt_s = c.gt_m;
      n.lk_m = lk; n.lk_s = c.lk_m;
      return n;
   endfunction

   // Reset pattern {refclk, mmcm, xcvr, resetl} per state
   function automatic logic [3:0] rst_pat(input int st);
      case (st)
         0, 6: return 4'b1110;
         1:    return 4'b0110;
         2, 3: return 4'b0010;
         default: return 4'b0001;
      endcase
   endfunction

   function automatic logic [13:0] model_pack(input model_t c);
      return {3'(c.st), 4'(c.retry), (c.st == 5), c.link, (c.st == 6), rst_pat(c.st)};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_step(m, mmcm_locked, gtpowergood, rx_block_lock, restart);
   end

   always @(negedge clk) begin
      if (chk_en)
         check("model_cmp", {18'd0, state, retry_cnt, ready, link_ok, fault,
                             qsfp_refclk_reset, mmcm_rst, xcvr_rst, qsfp_resetl},
               {18'd0, model_pack(m)});
   end

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       mm, gt;
      logic [3:0] lk;
      logic       rs;
      int         n;
      int         st;
      logic       rdy, lnk, flt;
      int         rty;
      logic [3:0] rst;
   } vec_t;

   function automatic vec_t mk(input logic mm, input logic gt, input logic [3:0] lk,
                               input logic rs, input int n, input int st, input logic rdy,
                               input logic lnk, input logic flt, input int rty,
                               input logic [3:0] rst);
      vec_t v;
      v.mm = mm; v.gt = gt; v.lk = lk; v.rs = rs; v.n = n; v.st = st;
      v.rdy = rdy; v.lnk = lnk; v.flt = flt; v.rty = rty; v.rst = rst;
      return v;
   endfunction

   vec_t vecs[$];
   int   seg_left;
   bit   seen;

   initial begin
      // nominal bring-up from reset release
      vecs.push_back(mk(1, 1, 4'hF, 0,  7, 0, 0, 0, 0, 0, 4'b1110));
      vecs.push_back(mk(1, 1, 4'hF, 0,  1, 1, 0, 0, 0, 0, 4'b0110));
      vecs.push_back(mk(1, 1, 4'hF, 0,  3, 1, 0, 0, 0, 0, 4'b0110));
      vecs.push_back(mk(1, 1, 4'hF, 0,  1, 2, 0, 0, 0, 0, 4'b0010));
      vecs.push_back(mk(1, 1, 4'hF, 0,  1, 3, 0, 0, 0, 0, 4'b0010));
      vecs.push_back(mk(1, 1, 4'hF, 0,  1, 4, 0, 1, 0, 0, 4'b0001));
      vecs.push_back(mk(1, 1, 4'hF, 0,  1, 5, 1, 1, 0, 0, 4'b0001));
      // MMCM drops in RUN, then re-locks
      vecs.push_back(mk(0, 1, 4'hF, 0,  3, 0, 0, 0, 0, 1, 4'b1110));
      vecs.push_back(mk(1, 1, 4'hF, 0, 15, 5, 1, 1, 0, 1, 4'b0001));
      // restart, then MMCM never locks: three timeouts then FAULT
      vecs.push_back(mk(0, 1, 4'hF, 1,  1, 0, 0, 0, 0, 0, 4'b1110));
      vecs.push_back(mk(0, 1, 4'hF, 0, 43, 2, 0, 0, 0, 0, 4'b0010));
      vecs.push_back(mk(0, 1, 4'hF, 0,  1, 0, 0, 0, 0, 1, 4'b1110));
      vecs.push_back(mk(0, 1, 4'hF, 0, 43, 2, 0, 0, 0, 1, 4'b0010));
      vecs.push_back(mk(0, 1, 4'hF, 0,  1, 0, 0, 0, 0, 2, 4'b1110));
      vecs.push_back(mk(0, 1, 4'hF, 0, 43, 2, 0, 0, 0, 2, 4'b0010));
      vecs.push_back(mk(0, 1, 4'hF, 0,  1, 6, 0, 0, 1, 2, 4'b1110));
      vecs.push_back(mk(0, 1, 4'hF, 0,  5, 6, 0, 0, 1, 2, 4'b1110));
      // restart while in FAULT
      vecs.push_back(mk(0, 1, 4'hF, 1,  1, 0, 0, 0, 0, 0, 4'b1110));

      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;
      mmcm_locked = 1'b1; gtpowergood = 1'b1; rx_block_lock = 4'hF;
      repeat (3) tick();
      check("reset_state", state, 0);
      check("reset_pattern", {qsfp_refclk_reset, mmcm_rst, xcvr_rst, qsfp_resetl}, 4'b1110);
      check("reset_flags", {ready, link_ok, fault, retry_cnt}, 7'd0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         mmcm_locked = vecs[i].mm; gtpowergood = vecs[i].gt;
         rx_block_lock = vecs[i].lk; restart = vecs[i].rs;
         repeat (vecs[i].n) tick();
         restart = 1'b0;
         check($sformatf("vec%0d_state", i), state, vecs[i].st);
         check($sformatf("vec%0d_flags", i), {ready, link_ok, fault}, {vecs[i].rdy, vecs[i].lnk, vecs[i].flt});
         check($sformatf("vec%0d_retry", i), retry_cnt, vecs[i].rty);
         check($sformatf("vec%0d_resets", i), {qsfp_refclk_reset, mmcm_rst, xcvr_rst, qsfp_resetl}, vecs[i].rst);
      end

      // restart arriving on the same edge as an MMCM_WAIT timeout
      repeat (43) tick();
      check("tmo_pre_state", state, 2);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("tmo_restart_state", state, 0);
      check("tmo_restart_retry", retry_cnt, 0);

      // partial block lock: RUN after the LINK_WAIT timeout with link_ok low
      mmcm_locked = 1'b1; gtpowergood = 1'b1; rx_block_lock = 4'b0111;
      repeat (45) tick();
      check("partial_linkwait", state, 4);
      tick();
      check("partial_run_state", state, 5);
      check("partial_run_flags", {ready, link_ok}, 2'b10);
      rx_block_lock = 4'hF;
      seen = 1'b0;
      for (int k = 0; k < 3 && !seen; k++) begin
         tick();
         if (link_ok) seen = 1'b1;
      end
      check("late_lock_link_ok", seen, 1);

      // asynchronous reset in the middle of LINK_WAIT
      restart = 1'b1; rx_block_lock = 4'b0111;
      tick();
      restart = 1'b0;
      repeat (20) tick();
      check("async_pre_state", state, 4);
      #1 rst_n = 1'b0;
      #1;
      check("async_state", state, 0);
      check("async_resets", {qsfp_refclk_reset, mmcm_rst, xcvr_rst, qsfp_resetl}, 4'b1110);
      check("async_flags", {ready, link_ok, fault, retry_cnt}, 7'd0);
      tick();
      rst_n = 1'b1;
      repeat (7) tick();
      check("rerelease_hold", state, 0);
      tick();
      check("rerelease_settle", {state, qsfp_refclk_reset}, {3'd1, 1'b0});

      // randomized stimulus, compared cycle by cycle against the model
      seg_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if (seg_left == 0) begin
            seg_left = $urandom_range(1, 40);
            mmcm_locked = ($urandom_range(0, 9) != 0);
            gtpowergood = ($urandom_range(0, 9) != 0);
            for (int b = 0; b < 4; b++) rx_block_lock[b] = ($urandom_range(0, 4) != 0);
         end
         seg_left--;
         restart = ($urandom_range(0, 99) < 2);
         if ($urandom_range(0, 399) == 0) begin
            #1 rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end
      restart = 1'b0;
      tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
